// File: rtl/eth_rt_tx_arbiter_if.sv
// Transmit-path arbitration bundle: requester levels, one-hot grant, engine start/select and engine busy.
interface eth_rt_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               txStart;
    logic [1:0]         txSel;
    logic               txBusy;

    modport master (output req, output txBusy, input grant, input txStart, input txSel);
    modport slave  (input req, input txBusy, output grant, output txStart, output txSel);
endinterface

// File: rtl/eth_rt_tx_arbiter.sv
// Real-time Ethernet TX arbiter: fixed priority for index 0, round-robin for 1..NUM_REQ-1, IPG and stall timeouts.
// Optional ETH_ARB_STATS_EN adds per-requester grant counters and a BUSY-length high-water mark.
module eth_rt_tx_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int IPG_CLKS      = 12,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_BUSY      = 4000
) (
    input  logic                clk,
    input  logic                reset,
    eth_rt_tx_arbiter_if.slave  arb,
    input  logic                clearErrors,
    output logic                arbError,
    input  logic [15:0]         reg_raddr,
    output logic [31:0]         reg_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, GAP = 2'd3} state_t;

    localparam logic [1:0]  LAST_IDX    = 2'(NUM_REQ - 1);
    localparam logic [15:0] START_LIMIT = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LIMIT  = 16'(MAX_BUSY - 1);
    localparam logic [15:0] IPG_LIMIT   = 16'(IPG_CLKS - 1);

    state_t             state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic               tx_start_reg;
    logic [1:0]         tx_sel_reg;
    logic [1:0]         last_idx_reg;
    logic [15:0]        cnt_reg;
    logic               start_timeout_reg;
    logic               busy_timeout_reg;

    logic [3:0]         req_pad;
    logic [3:0]         grant_pad;
    logic [1:0]         winner;
    logic               winner_valid;
    logic [NUM_REQ-1:0] winner_onehot;
    logic               unused_raddr;

    assign req_pad      = 4'(arb.req);
    assign grant_pad    = 4'(grant_reg);
    assign unused_raddr = ^reg_raddr[15:8];

    // Index 0 pre-empts; otherwise scan from lastIdx+1, wrapping back to 1 (never to 0).
    always_comb begin
        logic [1:0] idx;
        idx          = last_idx_reg;
        winner       = 2'd0;
        winner_valid = 1'b0;
        if (req_pad[0]) begin
            winner_valid = 1'b1;
        end else begin
            for (int k = 1; k < NUM_REQ; k++) begin
                idx = (idx >= LAST_IDX) ? 2'd1 : idx + 2'd1;
                if (req_pad[idx] && !winner_valid) begin
                    winner       = idx;
                    winner_valid = 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign winner_onehot[gi] = (winner == 2'(gi));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            grant_reg         <= '0;
            tx_start_reg      <= 1'b0;
            tx_sel_reg        <= 2'd0;
            last_idx_reg      <= LAST_IDX;
            cnt_reg           <= 16'd0;
            start_timeout_reg <= 1'b0;
            busy_timeout_reg  <= 1'b0;
        end else begin
            // Clear first so a timeout set in the same cycle overrides it.
            if (clearErrors) begin
                start_timeout_reg <= 1'b0;
                busy_timeout_reg  <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (winner_valid) begin
                        grant_reg    <= winner_onehot;
                        tx_sel_reg   <= winner;
                        tx_start_reg <= 1'b1;
                        cnt_reg      <= 16'd0;
                        state_reg    <= START;
                        if (winner != 2'd0) last_idx_reg <= winner;
                    end
                end
                START: begin
                    tx_start_reg <= 1'b0;
                    cnt_reg      <= cnt_reg + 16'd1;
                    if (arb.txBusy) begin
                        cnt_reg   <= 16'd0;
                        state_reg <= BUSY;
                    end else if (cnt_reg == START_LIMIT) begin
                        start_timeout_reg <= 1'b1;
                        grant_reg         <= '0;
                        cnt_reg           <= 16'd0;
                        state_reg         <= GAP;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 16'd1;
                    if (!arb.txBusy) begin
                        grant_reg <= '0;
                        cnt_reg   <= 16'd0;
                        state_reg <= GAP;
                    end else if (cnt_reg == BUSY_LIMIT) begin
                        busy_timeout_reg <= 1'b1;
                        grant_reg        <= '0;
                        cnt_reg          <= 16'd0;
                        state_reg        <= GAP;
                    end
                end
                GAP: begin
                    // A stalled engine keeps the gap counter pinned until it finally drops busy.
                    if (arb.txBusy) begin
                        cnt_reg <= 16'd0;
                    end else if (cnt_reg == IPG_LIMIT) begin
                        cnt_reg   <= 16'd0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign arb.grant   = grant_reg;
    assign arb.txStart = tx_start_reg;
    assign arb.txSel   = tx_sel_reg;
    assign arbError    = start_timeout_reg | busy_timeout_reg;

`ifdef ETH_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_reg;
    logic [NUM_REQ-1:0][15:0] grant_cnt_next;
    logic [15:0]              max_busy_reg;
    logic [15:0]              max_busy_next;
    logic [15:0]              max_busy_base;
    logic [15:0]              busy_len;
    logic                     busy_exit;
    logic                     grant_event;

    assign grant_event   = (state_reg == IDLE) && winner_valid;
    assign busy_len      = cnt_reg + 16'd1;
    assign busy_exit     = (state_reg == BUSY) && (!arb.txBusy || (cnt_reg == BUSY_LIMIT));
    assign max_busy_base = clearErrors ? 16'd0 : max_busy_reg;
    assign max_busy_next = (busy_exit && (busy_len > max_busy_base)) ? busy_len : max_busy_base;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        assign grant_cnt_next[gi] = (clearErrors ? 16'd0 : grant_cnt_reg[gi])
                                  + {15'd0, grant_event & winner_onehot[gi]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_reg <= '0;
            max_busy_reg  <= 16'd0;
        end else begin
            grant_cnt_reg <= grant_cnt_next;
            max_busy_reg  <= max_busy_next;
        end
    end
`endif

    always_comb begin
        reg_rdata = 32'd0;
        if (reg_raddr[7:4] == 4'hb) begin
            if (reg_raddr[3:0] == 4'd0) begin
                reg_rdata = {16'd0, last_idx_reg, state_reg, 2'd0,
                             busy_timeout_reg, start_timeout_reg, 4'd0, grant_pad};
            end
`ifdef ETH_ARB_STATS_EN
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reg_raddr[3:0] == 4'(i + 1)) reg_rdata = {16'd0, grant_cnt_reg[i]};
            end
            if (reg_raddr[3:0] == 4'd7) reg_rdata = {16'd0, max_busy_reg};
`endif
        end
    end
endmodule

// File: tb/tb_eth_rt_tx_arbiter.sv
// Directed bench for eth_rt_tx_arbiter: priority, round-robin, IPG, timeouts, async reset and statistics.
`timescale 1ns/1ps
module tb_eth_rt_tx_arbiter;
    localparam int NUM_REQ = 3;
`ifdef ETH_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clearErrors;
    logic        arbError;
    logic [15:0] reg_raddr;
    logic [31:0] reg_rdata;

    eth_rt_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) arb ();

    eth_rt_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .IPG_CLKS(12), .START_TIMEOUT(16), .MAX_BUSY(4000)
    ) dut (
        .clk(clk), .reset(reset), .arb(arb), .clearErrors(clearErrors),
        .arbError(arbError), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_cnt [NUM_REQ];
    int model_max;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_reg(input logic [3:0] off, output logic [31:0] data);
        reg_raddr = {8'h00, 4'hb, off};
        #1;
        data = reg_rdata;
    endtask

    function automatic int idx_of(input logic [2:0] g);
        case (g)
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REQ; i++) model_cnt[i] = 0;
        model_max = 0;
    endtask

    // One complete transfer: request, grant, one-cycle start, busy for busy_cycles, release.
    task automatic transfer(input string tag, input logic [2:0] req_v, input bit hold,
                            input int busy_cycles, input logic [2:0] exp_grant, input int exp_wait);
        int waited;
        waited  = 0;
        arb.req = req_v;
        while (arb.grant == '0 && waited < 40) begin
            step();
            waited++;
        end
        check({tag, "_grant"}, 32'(arb.grant), 32'(exp_grant));
        check({tag, "_start"}, 32'(arb.txStart), 32'd1);
        check({tag, "_sel"}, 32'(arb.txSel), 32'(idx_of(exp_grant)));
        if (exp_wait >= 0) check({tag, "_latency"}, 32'(waited), 32'(exp_wait));
        if (!hold) arb.req = '0;
        model_cnt[idx_of(exp_grant)]++;
        arb.txBusy = 1'b1;
        step();
        check({tag, "_start_pulse"}, 32'(arb.txStart), 32'd0);
        step(busy_cycles - 1);
        check({tag, "_held"}, 32'(arb.grant), 32'(exp_grant));
        arb.txBusy = 1'b0;
        step();
        check({tag, "_release"}, 32'(arb.grant), 32'd0);
        if (busy_cycles > model_max) model_max = busy_cycles;
        $display("[TB] %s: req=%b granted idx %0d, waited %0d, busy %0d clocks",
                 tag, req_v, idx_of(exp_grant), waited, busy_cycles);
    endtask

    task automatic check_stats(input string tag);
        logic [31:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            read_reg(4'(i + 1), d);
            check($sformatf("%s_cnt%0d", tag, i), d, STATS ? 32'(model_cnt[i]) : 32'd0);
        end
        read_reg(4'd7, d);
        check({tag, "_max_busy"}, d, STATS ? 32'(model_max) : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          cnt;
        reset       = 1'b0;
        clearErrors = 1'b0;
        reg_raddr   = 16'd0;
        arb.req     = '0;
        arb.txBusy  = 1'b0;
        model_clear();
        step(3);

        // Reset state
        check("rst_grant", 32'(arb.grant), 32'd0);
        check("rst_start", 32'(arb.txStart), 32'd0);
        check("rst_sel", 32'(arb.txSel), 32'd0);
        check("rst_err", 32'(arbError), 32'd0);
        read_reg(4'd0, d);
        check("rst_reg0", d, 32'h0000_8000);
        check_stats("rst");
        reset = 1'b1;
        step(2);

        // Single request, then IPG latency for the following grant
        transfer("single", 3'b010, 1'b0, 100, 3'b010, 1);
        transfer("after_gap", 3'b100, 1'b0, 5, 3'b100, 13);

        // Fixed priority of index 0, then round-robin among 1..2
        for (int i = 0; i < 3; i++) transfer("prio", 3'b111, 1'b1, 4, 3'b001, -1);
        for (int i = 0; i < 4; i++) transfer("rr", 3'b110, 1'b1, 4, (i % 2 == 0) ? 3'b010 : 3'b100, -1);
        arb.req = '0;

        // Start timeout: engine never raises busy
        arb.req = 3'b001;
        cnt = 0;
        while (arb.grant == '0 && cnt < 40) begin step(); cnt++; end
        check("sto_grant", 32'(arb.grant), 32'b001);
        arb.req = '0;
        model_cnt[0]++;
        cnt = 0;
        while (arb.grant != '0 && cnt < 40) begin step(); cnt++; end
        check("sto_len", 32'(cnt), 32'd16);
        check("sto_err", 32'(arbError), 32'd1);
        read_reg(4'd0, d);
        check("sto_reg0", d, 32'h0000_B100);
        clearErrors = 1'b1;
        step();
        clearErrors = 1'b0;
        check("sto_clear", 32'(arbError), 32'd0);
        $display("[TB] start_timeout: grant dropped after %0d clocks", cnt);

        // Busy timeout: engine stuck high for 5000 clocks
        arb.req = 3'b010;
        cnt = 0;
        while (arb.grant == '0 && cnt < 40) begin step(); cnt++; end
        check("bto_grant", 32'(arb.grant), 32'b010);
        arb.req = '0;
        model_cnt[1]++;
        arb.txBusy = 1'b1;
        cnt = 0;
        while (arb.grant != '0 && cnt < 4100) begin step(); cnt++; end
        check("bto_len", 32'(cnt), 32'd4001);
        check("bto_err", 32'(arbError), 32'd1);
        read_reg(4'd0, d);
        check("bto_reg0", d, 32'h0000_7200);
        if (model_max < 4000) model_max = 4000;
        arb.req = 3'b100;
        step(999);
        check("bto_no_grant", 32'(arb.grant), 32'd0);
        arb.txBusy = 1'b0;
        cnt = 0;
        while (arb.grant == '0 && cnt < 40) begin step(); cnt++; end
        check("bto_gap", 32'(cnt), 32'd13);
        check("bto_next_grant", 32'(arb.grant), 32'b100);
        arb.req = '0;
        $display("[TB] busy_timeout: grant dropped after %0d clocks, next grant %0d after busy fell", 4001, cnt);

        // Asynchronous reset in the middle of BUSY
        arb.txBusy = 1'b1;
        step(3);
        check("ar_err_before", 32'(arbError), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("ar_grant", 32'(arb.grant), 32'd0);
        check("ar_start", 32'(arb.txStart), 32'd0);
        check("ar_err", 32'(arbError), 32'd0);
        #1 reset = 1'b1;
        arb.txBusy = 1'b0;
        model_clear();
        step();
        $display("[TB] async_reset: outputs cleared mid-BUSY");
        transfer("post_reset", 3'b100, 1'b0, 6, 3'b100, 1);

        // busy falling on the same edge as the busy-timeout compare: normal end, no error
        transfer("busy_edge", 3'b001, 1'b0, 4000, 3'b001, -1);
        check("busy_edge_err", 32'(arbError), 32'd0);
        check_stats("pre_clear");

        // Statistics: 5 grants to index 1, 3 to index 2 after a clear
        clearErrors = 1'b1;
        step();
        clearErrors = 1'b0;
        model_clear();
        check_stats("cleared");
        transfer("stat", 3'b110, 1'b1, 3,  3'b010, -1);
        transfer("stat", 3'b110, 1'b1, 7,  3'b100, -1);
        transfer("stat", 3'b110, 1'b1, 37, 3'b010, -1);
        transfer("stat", 3'b110, 1'b1, 4,  3'b100, -1);
        transfer("stat", 3'b110, 1'b1, 5,  3'b010, -1);
        transfer("stat", 3'b110, 1'b1, 6,  3'b100, -1);
        transfer("stat", 3'b010, 1'b0, 8,  3'b010, -1);
        transfer("stat", 3'b010, 1'b0, 2,  3'b010, -1);
        check_stats("final");
        read_reg(4'd4, d);
        check("off4", d, 32'd0);
        reg_raddr = 16'h00a0;
        #1;
        check("other_space", reg_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
